// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: ID/EXE/MEM hazard inputs and pipeline-control outputs
interface pipeline_hazard_controller_if;
  logic [3:0] id_src1_in;
  logic [3:0] id_src2_in;
  logic id_has_src1_in;
  logic id_has_src2_in;
  logic [3:0] exe_dest_in;
  logic exe_wb_en_in;
  logic exe_mem_r_en_in;
  logic branch_taken_in;
  logic [3:0] mem_dest_in;
  logic mem_wb_en_in;
  logic mem_access_in;
  logic mem_ready_in;
  logic use_forwarding_in;
  logic freeze_if_out;
  logic freeze_id_out;
  logic bubble_exe_out;
  logic flush_out;
  logic freeze_all_out;
  logic mem_req_out;
  logic [15:0] stall_count_out;
  modport master (
    output id_src1_in, id_src2_in, id_has_src1_in, id_has_src2_in,
    output exe_dest_in, exe_wb_en_in, exe_mem_r_en_in, branch_taken_in,
    output mem_dest_in, mem_wb_en_in, mem_access_in, mem_ready_in, use_forwarding_in,
    input freeze_if_out, freeze_id_out, bubble_exe_out, flush_out,
    input freeze_all_out, mem_req_out, stall_count_out
  );
  modport slave (
    input id_src1_in, id_src2_in, id_has_src1_in, id_has_src2_in,
    input exe_dest_in, exe_wb_en_in, exe_mem_r_en_in, branch_taken_in,
    input mem_dest_in, mem_wb_en_in, mem_access_in, mem_ready_in, use_forwarding_in,
    output freeze_if_out, freeze_id_out, bubble_exe_out, flush_out,
    output freeze_all_out, mem_req_out, stall_count_out
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: data-hazard stall, branch flush and memory-wait freeze with stall counter
module pipeline_hazard_controller (
  input logic clk,
  input logic rst_n,
  pipeline_hazard_controller_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;
  logic hz_exe, hz_mem, raw_stall, stall, flush, freeze_all;
  logic [15:0] stall_count;
  assign hz_exe = bus.exe_wb_en_in & ((bus.id_has_src1_in & (bus.id_src1_in == bus.exe_dest_in)) |
                                      (bus.id_has_src2_in & (bus.id_src2_in == bus.exe_dest_in)));
  assign hz_mem = bus.mem_wb_en_in & ((bus.id_has_src1_in & (bus.id_src1_in == bus.mem_dest_in)) |
                                      (bus.id_has_src2_in & (bus.id_src2_in == bus.mem_dest_in)));
  assign raw_stall = bus.use_forwarding_in ? (hz_exe & bus.exe_mem_r_en_in) : (hz_exe | hz_mem);
  // memory freeze outranks flush, which outranks the hazard stall
  assign flush = bus.branch_taken_in & ~freeze_all;
  assign stall = raw_stall & ~freeze_all & ~flush;
  always_comb begin
    state_nxt = RUN;
    freeze_all = 1'b0;
    state_nxt = (state == RUN) ? (bus.mem_access_in ? WAIT : RUN) :
                (state == WAIT) ? (bus.mem_ready_in ? DONE : WAIT) : RUN;
    freeze_all = (state == WAIT) | ((state == RUN) & bus.mem_access_in);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      if ((freeze_all | stall) && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  assign bus.freeze_if_out = stall;
  assign bus.freeze_id_out = stall;
  assign bus.bubble_exe_out = stall;
  assign bus.flush_out = flush;
  assign bus.freeze_all_out = freeze_all;
  assign bus.mem_req_out = (state == WAIT);
  assign bus.stall_count_out = stall_count;
endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-002 The ID-stage source ports SHALL be: id_src1_in  in  4  ID source reg 1; id_src2_in  in  4  ID source reg 2; id_has_src1_in  in  1  src1 valid; id_has_src2_in  in  1  src2 valid.
REQ-003 The EXE-stage ports SHALL be: exe_dest_in  in  4  EXE dest reg; exe_wb_en_in  in  1  EXE writes back; exe_mem_r_en_in  in  1  EXE is a load; branch_taken_in  in  1  EXE branch taken.
REQ-004 The MEM-stage ports SHALL be: mem_dest_in  in  4  MEM dest reg; mem_wb_en_in  in  1  MEM writes back; mem_access_in  in  1  MEM holds a valid load/store; mem_ready_in  in  1  cache/SRAM completes the access.
REQ-005 The configuration port SHALL be: use_forwarding_in  in  1  forwarding enabled.
REQ-006 The pipeline-control outputs SHALL be: freeze_if_out  out  1  hold PC/IF-ID; freeze_id_out  out  1  hold ID; bubble_exe_out  out  1  load NOP into ID-EXE; flush_out  out  1  flush IF-ID and ID-EXE.
REQ-007 The memory and status outputs SHALL be: freeze_all_out  out  1  hold every pipeline register; mem_req_out  out  1  access request to cache; stall_count_out  out  16  saturating stall-cycle count.

Function
REQ-008 The FSM SHALL have states RUN, WAIT and DONE, encoded in 2 bits, with the encoding value 3 returning to RUN.
REQ-009 In RUN with mem_access_in=1, the block SHALL assert freeze_all_out (combinational) and move to WAIT at the next edge; otherwise it SHALL stay in RUN.
REQ-010 In WAIT, the block SHALL assert mem_req_out=1 and freeze_all_out=1, and move to DONE on the edge where mem_ready_in=1.
REQ-011 In DONE, the block SHALL drive freeze_all_out=0 and mem_req_out=0, ignore mem_access_in (the completed access retires this cycle), and return to RUN unconditionally.
REQ-012 mem_ready_in SHALL be ignored outside WAIT, and mem_req_out SHALL be a decode of the state only (glitch-free).
REQ-013 The block SHALL compute hz_exe = exe_wb_en_in & ((id_has_src1_in & id_src1_in==exe_dest_in) | (id_has_src2_in & id_src2_in==exe_dest_in)), and hz_mem likewise against mem_dest_in/mem_wb_en_in.
REQ-014 The raw stall SHALL be hz_exe | hz_mem when use_forwarding_in=0, and hz_exe & exe_mem_r_en_in (load-use) when use_forwarding_in=1.
REQ-015 flush_out SHALL equal branch_taken_in & ~freeze_all_out.
REQ-016 freeze_if_out, freeze_id_out and bubble_exe_out SHALL each equal raw stall & ~freeze_all_out & ~flush_out; flush has priority over hazard stall, and memory freeze has priority over both.
REQ-017 All control outputs other than mem_req_out and stall_count_out SHALL be combinational, with zero-cycle latency.
REQ-018 stall_count_out SHALL increment by 1 on each rising edge where freeze_all_out | freeze_id_out is 1, and SHALL saturate at 16'hFFFF without wrapping.

Reset
REQ-019 On rst_n=0, the block SHALL asynchronously set state to RUN and stall_count_out to 0, with mem_req_out=0 immediately, including when reset is asserted mid-WAIT.
REQ-020 After rst_n deasserts, the block SHALL start operation at the first rising clk edge.
REQ-021 While in reset, the combinational outputs SHALL follow their inputs with state=RUN.

Verification
REQ-022 Load-use: fwd=1, exe_mem_r_en=1, exe_dest=3, exe_wb_en=1, id_src1=3, has_src1=1 -> freeze_if/freeze_id/bubble_exe=1, count +1; same with exe_mem_r_en=0 -> all 0.
REQ-023 No forwarding: fwd=0, mem_dest=5, mem_wb_en=1, id_src2=5, has_src2=1 -> stall=1; has_src2=0 -> stall=0.
REQ-024 Memory wait: mem_access=1 in RUN, mem_ready=1 on the 3rd WAIT cycle -> freeze_all high for 4 cycles, mem_req high for 3 cycles, then DONE with freeze_all=0, then RUN; count=4.
REQ-025 Priority: branch_taken=1 with a load-use hazard -> flush=1 and bubble=0; branch_taken=1 during WAIT -> flush=0.
REQ-026 Reset mid-WAIT: assert rst_n=0 between edges -> mem_req_out=0 and count=0 immediately; after release, mem_access=0 keeps the FSM in RUN.
REQ-027 Saturation: preload the count via 65535 frozen cycles, then one more -> stall_count_out stays 16'hFFFF.
